alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Control-step generator on the initiator side of the ALU datapath interface: issues the Y load, ALU control code, ALU strobe, Z capture and writeback strobes for one register-register or unary ALU instruction.
- Accepts one decoded operation (opcode plus register fields) per start pulse.
- Walks a fixed Moore FSM, then returns to idle.
- Sits between instruction decode and the bus/register-file/Y/Z/HI/LO enables.

Parameters:
- REG_W, 4, width of register select fields.
- OP_W, 5, width of ALU control code (encoding fixed below).

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  synchronous active-low reset, sampled on rising edge of clock.
- start  in  1  request; accepted only in IDLE.
- opcode  in  OP_W  ALU operation code.
- ra  in  REG_W  destination register.
- rb  in  REG_W  first operand register (goes to Y).
- rc  in  REG_W  second operand register (driven on bus).
- rsel  out  REG_W  register-file read select for bus drive.
- rout  out  1  register-file drives bus.
- yin  out  1  Y register load.
- alu_control  out  OP_W  code presented to ALU.
- alu_in  out  1  ALU evaluate strobe.
- zin  out  1  Z register (64-bit) load.
- zlo_out  out  1  Z[31:0] drives bus.
- zhi_out  out  1  Z[63:32] drives bus.
- wsel  out  REG_W  register-file write select.
- rin  out  1  register-file write enable.
- lo_in  out  1  LO load.
- hi_in  out  1  HI load.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle illegal-opcode pulse.

Behaviour:
- Reset: when clear=0 at a clock edge, state goes to IDLE and the latched op/ra/rb/rc fields go to 0. Every output is 0 from the following cycle. This applies mid-sequence: no further strobes from the aborted op.
- All outputs are Moore, decoded from state plus latched fields only. No combinational path from the inputs to the outputs.
- Legal opcodes:
  - binary: 00011 add, 00100 sub, 00101 and, 00110 or, 01111 mul, 10000 div.
  - unary: 00111 shr, 01000 shra, 01001 shl, 01010 ror, 01011 rol, 10001 neg, 10010 not.
  - All other codes are illegal.
- IDLE: all outputs 0.
  - start=1 with a legal opcode: latch opcode/ra/rb/rc, go to LOADY.
  - start=1 with an illegal opcode: go to ERR; fields are not latched.
- ERR: err=1 for one cycle, everything else 0, then IDLE.
- LOADY: rsel=rb, rout=1, yin=1, busy=1, alu_control=latched op. Next state EXEC.
- EXEC: alu_control=op, alu_in=1, zin=1, busy=1.
  - Binary op: rsel=rc, rout=1.
  - Unary op: rout=0, rsel=0.
  - Next state WBLO.
- WBLO: zlo_out=1, busy=1, alu_control=op.
  - mul/div: lo_in=1, rin=0, next state WBHI.
  - Otherwise: rin=1, wsel=ra, next state DONE.
- WBHI (mul/div only): zhi_out=1, hi_in=1, busy=1, alu_control=op. Next state DONE.
- DONE: done=1, busy=1, all strobes 0, alu_control=op. Next state IDLE.
- alu_control holds the latched op from LOADY through DONE; it is 0 in IDLE and ERR.
- start is ignored in every state except IDLE, including DONE, so back-to-back ops are spaced by at least one IDLE cycle.
- Latency from the start-accept edge to the done pulse: 4 cycles normal, 5 cycles mul/div.
- Exclusivity: never more than one bus driver per cycle (rout, zlo_out, zhi_out mutually exclusive). yin and zin are never asserted in the same cycle.
- ra, rb and rc may be equal. Operand registers are read before the writeback cycle, so no hazard.
- Changes on opcode/ra/rb/rc after accept have no effect on the running sequence.

Test Plan:
- Reset: hold clear=0 for 2 cycles with start=1, opcode=00011 -> all outputs 0, stays IDLE; release clear -> accepts on the next start.
- add: start with opcode=00011, ra=3, rb=1, rc=2. Per cycle after accept:
  - LOADY: rsel=1, rout=1, yin=1.
  - EXEC: rsel=2, rout=1, alu_in=1, zin=1, alu_control=00011.
  - WBLO: zlo_out=1, rin=1, wsel=3.
  - DONE: done=1.
  - Then IDLE, busy=0.
- mul: opcode=01111, rb=4, rc=5.
  - WBLO: zlo_out=1, lo_in=1, rin=0.
  - WBHI: zhi_out=1, hi_in=1.
  - done lands 5 cycles after accept; never rin=1.
- Unary not: opcode=10010, ra=6, rb=7 -> EXEC has rout=0, alu_in=1; WBLO has wsel=6, rin=1. Also check the one-hot bus-driver assertion across all legal opcodes.
- Illegal and overlap:
  - opcode=01100 -> err=1 for exactly one cycle, busy=0 throughout.
  - start held high continuously with add -> ops accepted every 5 cycles.
  - opcode/rb changed mid-sequence -> no effect on outputs.
- Reset mid-op: clear=0 at the edge entering WBLO of a div -> no zlo_out/lo_in/hi_in/done pulse afterwards; all outputs 0.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Moore control-step sequencer for one ALU instruction: Y load, ALU strobe, Z capture, writeback.
// Done is 4 cycles after the start cycle (5 for mul/div). start is only honoured in IDLE, so there is no backpressure.
module alu_op_sequencer #(
  parameter int REG_W = 4,
  parameter int OP_W  = 5
) (
  input  logic             i_clock,
  input  logic             i_clear,
  input  logic             i_start,
  input  logic [OP_W-1:0]  i_opcode,
  input  logic [REG_W-1:0] i_ra,
  input  logic [REG_W-1:0] i_rb,
  input  logic [REG_W-1:0] i_rc,
  output logic [REG_W-1:0] o_rsel,
  output logic             o_rout,
  output logic             o_yin,
  output logic [OP_W-1:0]  o_alu_control,
  output logic             o_alu_in,
  output logic             o_zin,
  output logic             o_zlo_out,
  output logic             o_zhi_out,
  output logic [REG_W-1:0] o_wsel,
  output logic             o_rin,
  output logic             o_lo_in,
  output logic             o_hi_in,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ERR, S_LOADY, S_EXEC, S_WBLO, S_WBHI, S_DONE
  } state_t;

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(5'b00011);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(5'b00100);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(5'b00101);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(5'b00110);
  localparam logic [OP_W-1:0] OP_SHR  = OP_W'(5'b00111);
  localparam logic [OP_W-1:0] OP_SHRA = OP_W'(5'b01000);
  localparam logic [OP_W-1:0] OP_SHL  = OP_W'(5'b01001);
  localparam logic [OP_W-1:0] OP_ROR  = OP_W'(5'b01010);
  localparam logic [OP_W-1:0] OP_ROL  = OP_W'(5'b01011);
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(5'b01111);
  localparam logic [OP_W-1:0] OP_DIV  = OP_W'(5'b10000);
  localparam logic [OP_W-1:0] OP_NEG  = OP_W'(5'b10001);
  localparam logic [OP_W-1:0] OP_NOT  = OP_W'(5'b10010);

  function automatic logic is_muldiv(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_binary(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_DIV: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

  function automatic logic is_unary(input logic [OP_W-1:0] op);
    case (op)
      OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL, OP_NEG, OP_NOT: return 1'b1;
      default:                                                return 1'b0;
    endcase
  endfunction

  state_t           r_state;
  state_t           w_next;
  logic [OP_W-1:0]  r_op;
  logic [REG_W-1:0] r_ra;
  logic [REG_W-1:0] r_rb;
  logic [REG_W-1:0] r_rc;
  logic             w_legal;
  logic             w_accept;

  assign w_legal  = is_binary(i_opcode) || is_unary(i_opcode);
  assign w_accept = (r_state == S_IDLE) && i_start && w_legal;

  always_ff @(posedge i_clock) begin
    if (!i_clear) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_ra    <= '0;
      r_rb    <= '0;
      r_rc    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op <= i_opcode;
        r_ra <= i_ra;
        r_rb <= i_rb;
        r_rc <= i_rc;
      end
    end
  end

  // Outputs depend only on r_state and the latched fields.
  always_comb begin
    w_next        = r_state;
    o_rsel        = '0;
    o_rout        = 1'b0;
    o_yin         = 1'b0;
    o_alu_control = '0;
    o_alu_in      = 1'b0;
    o_zin         = 1'b0;
    o_zlo_out     = 1'b0;
    o_zhi_out     = 1'b0;
    o_wsel        = '0;
    o_rin         = 1'b0;
    o_lo_in       = 1'b0;
    o_hi_in       = 1'b0;
    o_busy        = 1'b0;
    o_done        = 1'b0;
    o_err         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = w_legal ? S_LOADY : S_ERR;
      end
      S_ERR: begin
        o_err  = 1'b1;
        w_next = S_IDLE;
      end
      S_LOADY: begin
        o_rsel        = r_rb;
        o_rout        = 1'b1;
        o_yin         = 1'b1;
        o_busy        = 1'b1;
        o_alu_control = r_op;
        w_next        = S_EXEC;
      end
      S_EXEC: begin
        o_alu_control = r_op;
        o_alu_in      = 1'b1;
        o_zin         = 1'b1;
        o_busy        = 1'b1;
        if (is_binary(r_op)) begin
          o_rsel = r_rc;
          o_rout = 1'b1;
        end
        w_next = S_WBLO;
      end
      S_WBLO: begin
        o_zlo_out     = 1'b1;
        o_busy        = 1'b1;
        o_alu_control = r_op;
        if (is_muldiv(r_op)) begin
          o_lo_in = 1'b1;
          w_next  = S_WBHI;
        end else begin
          o_rin  = 1'b1;
          o_wsel = r_ra;
          w_next = S_DONE;
        end
      end
      S_WBHI: begin
        o_zhi_out     = 1'b1;
        o_hi_in       = 1'b1;
        o_busy        = 1'b1;
        o_alu_control = r_op;
        w_next        = S_DONE;
      end
      S_DONE: begin
        o_done        = 1'b1;
        o_busy        = 1'b1;
        o_alu_control = r_op;
        w_next        = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: per-cycle expected output vectors queued at issue, compared at negedge.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       clear;
  logic       start;
  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic [3:0] rsel, wsel;
  logic [4:0] alu_control;
  logic       rout, yin, alu_in, zin, zlo_out, zhi_out, rin, lo_in, hi_in, busy, done, err;

  alu_op_sequencer #(.REG_W(4), .OP_W(5)) dut (
    .i_clock(clk), .i_clear(clear), .i_start(start), .i_opcode(opcode),
    .i_ra(ra), .i_rb(rb), .i_rc(rc),
    .o_rsel(rsel), .o_rout(rout), .o_yin(yin), .o_alu_control(alu_control),
    .o_alu_in(alu_in), .o_zin(zin), .o_zlo_out(zlo_out), .o_zhi_out(zhi_out),
    .o_wsel(wsel), .o_rin(rin), .o_lo_in(lo_in), .o_hi_in(hi_in),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [24:0] exp_q[$];
  bit          mon_en = 1'b0;
  logic [24:0] mon_exp;
  logic [24:0] obs;

  assign obs = {rsel, rout, yin, alu_control, alu_in, zin, zlo_out, zhi_out,
                wsel, rin, lo_in, hi_in, busy, done, err};

  task automatic chk(input string tag, input logic [24:0] got, input logic [24:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got %h want %h", tag, $time, got, want);
    end
  endtask

  function automatic logic [24:0] mk(
      input logic [3:0] f_rsel, input logic f_rout, input logic f_yin, input logic [4:0] f_ac,
      input logic f_alu, input logic f_zin, input logic f_zlo, input logic f_zhi,
      input logic [3:0] f_wsel, input logic f_rin, input logic f_lo, input logic f_hi,
      input logic f_busy, input logic f_done, input logic f_err);
    return {f_rsel, f_rout, f_yin, f_ac, f_alu, f_zin, f_zlo, f_zhi,
            f_wsel, f_rin, f_lo, f_hi, f_busy, f_done, f_err};
  endfunction

  // Idle cycles (empty queue) must show all outputs low.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 25'd0;
      chk("outputs", obs, mon_exp);
      chk("bus_excl", {23'd0, (32'(rout) + 32'(zlo_out) + 32'(zhi_out)) > 1, yin & zin}, 25'd0);
    end
  end

  task automatic run_op(input logic [4:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input bit hold, input bit scramble, input int abort_at);
    logic [24:0] seq[$];
    logic [24:0] dummy;
    logic [31:0] rnd;
    bit          bin, mdv, legal;
    int          n;
    bin   = (op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01111, 5'b10000});
    mdv   = (op inside {5'b01111, 5'b10000});
    legal = bin || (op inside {5'b00111, 5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b10001, 5'b10010});
    @(posedge clk); #1;
    start = 1'b1; opcode = op; ra = a; rb = b; rc = c;
    exp_q.push_back(25'd0);
    if (!legal) begin
      seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    end else begin
      seq.push_back(mk(b, 1, 1, op, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      if (bin) seq.push_back(mk(c, 1, 0, op, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      else     seq.push_back(mk(0, 0, 0, op, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      if (mdv) begin
        seq.push_back(mk(0, 0, 0, op, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0));
        seq.push_back(mk(0, 0, 0, op, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0));
      end else begin
        seq.push_back(mk(0, 0, 0, op, 0, 0, 1, 0, a, 1, 0, 0, 1, 0, 0));
      end
      seq.push_back(mk(0, 0, 0, op, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    end
    if (abort_at > 0)
      while (seq.size() > abort_at) dummy = seq.pop_back();
    foreach (seq[i]) exp_q.push_back(seq[i]);
    n = seq.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      start = hold;
      if (scramble) begin
        rnd = $urandom;
        {opcode, ra, rb, rc} = rnd[16:0];
      end
      if (abort_at > 0 && i == n - 1) clear = 1'b0;
    end
    if (abort_at > 0) begin
      @(posedge clk); #1;
      clear = 1'b1;
    end
  endtask

  logic [4:0] legal_ops[13] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001,
                                5'b01010, 5'b01011, 5'b01111, 5'b10000, 5'b10001, 5'b10010};
  logic [4:0] bad_ops[8]    = '{5'b00000, 5'b00001, 5'b00010, 5'b01100, 5'b01101, 5'b01110,
                                5'b10011, 5'b11111};

  initial begin
    logic [31:0] r;
    clear = 1'b0; start = 1'b1; opcode = 5'b00011; ra = 4'd3; rb = 4'd1; rc = 4'd2;
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    clear = 1'b1; start = 1'b0;
    @(posedge clk); #1;

    run_op(5'b00011, 4'd3, 4'd1, 4'd2, 1'b0, 1'b0, 0);   // add
    run_op(5'b01111, 4'd1, 4'd4, 4'd5, 1'b0, 1'b0, 0);   // mul
    run_op(5'b10010, 4'd6, 4'd7, 4'd0, 1'b0, 1'b0, 0);   // not
    run_op(5'b10000, 4'd2, 4'd8, 4'd9, 1'b0, 1'b0, 2);   // div, reset entering WBLO
    run_op(5'b01100, 4'd1, 4'd1, 4'd1, 1'b0, 1'b0, 0);   // illegal
    run_op(5'b00011, 4'd5, 4'd5, 4'd5, 1'b1, 1'b0, 0);   // start held high
    run_op(5'b00011, 4'd4, 4'd2, 4'd3, 1'b1, 1'b0, 0);
    run_op(5'b00011, 4'd7, 4'd1, 4'd1, 1'b0, 1'b0, 0);
    run_op(5'b00100, 4'd9, 4'd10, 4'd11, 1'b0, 1'b1, 0); // inputs scrambled mid-op
    run_op(5'b10000, 4'd12, 4'd13, 4'd14, 1'b0, 1'b1, 0);

    foreach (legal_ops[i]) begin
      r = $urandom;
      run_op(legal_ops[i], r[3:0], r[7:4], r[11:8], 1'b0, 1'b1, 0);
    end
    foreach (bad_ops[i]) run_op(bad_ops[i], 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 0);

    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;
    if (exp_q.size() != 0) chk("queue_drain", 25'(exp_q.size()), 25'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got timeout want finish", $time);
    $fatal(1);
  end

endmodule
